execute_muldiv_unit: RTL and testbench
======================================

// Module: execute_muldiv_unit
// PURPOSE
//   Iterative multiply/divide unit on the Execute side of the ID/EX pipeline register.
//   Takes MULT/MULTU/DIV/DIVU requests with operands latched from ID/EX and runs them
//   over WIDTH+2 cycles. Drives Stall back to hazard control so Decode/ID-EX hold
//   while busy, and updates the architectural HI/LO pair on completion.
// PARAMETERS
//   WIDTH  32  operand width; HI and LO are WIDTH bits each
// PORTS
//   Clk    in   1      rising-edge clock
//   Reset  in   1      asynchronous, active-low reset
//   Start  in   1      request valid; sampled in IDLE only
//   Op     in   2      00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
//   OpA    in   WIDTH  multiplicand / dividend (ReadData1 from ID/EX)
//   OpB    in   WIDTH  multiplier / divisor (ReadData2 from ID/EX)
//   Flush  in   1      abort the in-flight operation (branch/jump flush)
//   Stall  out  1      high whenever state != IDLE
//   Done   out  1      one-cycle pulse; HI/LO updated on this cycle
//   Hi     out  WIDTH  product[2W-1:W] or remainder
//   Lo     out  WIDTH  product[W-1:0] or quotient
// BEHAVIOUR
//   Reset (Reset=0, async): state=IDLE, Stall=0, Done=0, Hi=0, Lo=0; internal regs cleared.
//   FSM: IDLE -> RUN -> FIX -> DONE -> IDLE.
//   IDLE: on Start=1, capture Op, sign flags, and |OpA|,|OpB| for signed ops (raw for
//     unsigned); clear the accumulator and counter; go to RUN. Start=0 stays in IDLE.
//   RUN: one radix-2 step per cycle for exactly WIDTH cycles (counter 0..WIDTH-1), then FIX.
//     Mul: shift-add; 2W-bit accumulator.
//     Div: restoring; W+1-bit partial remainder.
//   FIX: signed ops only, applied in this cycle.
//     MULT: negate the 2W product if signA^signB.
//     DIV: negate quotient if signA^signB; remainder takes the sign of the dividend.
//   DONE: Hi/Lo <= result, Done=1 for one cycle, then IDLE. Stall is still 1 here.
//   Latency: Start sampled at edge N -> Done high in cycle N+WIDTH+2.
//     Stall is high from N+1 through the Done cycle.
//   Start while state != IDLE: ignored. No queuing; the upstream holds via Stall.
//   Flush in RUN/FIX: return to IDLE next edge. No Done. Hi/Lo unchanged.
//   Flush in DONE: ignored; the result commits. Flush in IDLE: no effect.
//   Flush and Start together in IDLE: Flush wins, request dropped.
//   Divide by zero (OpB=0): no trap. Runs full latency. Result Lo=all-ones, Hi=OpA (raw).
//   Signed DIV of most-negative by -1: Lo=most-negative, Hi=0 (wraps, no exception).
//   Hi/Lo hold between operations. Only the DONE state writes them.
//   Reset mid-operation: immediate return to reset values, Hi/Lo included.
// TESTING
//   MULTU 0xFFFFFFFF*0xFFFFFFFF -> Done at cycle 34 after Start; Hi=0xFFFFFFFE, Lo=0x00000001.
//   MULT -3*7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; DIV -7/2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
//   DIVU 100/0 -> Lo=0xFFFFFFFF, Hi=0x00000064. DIV 0x80000000/-1 -> Lo=0x80000000, Hi=0.
//   Start MULT, Flush at RUN cycle 10 -> Stall drops next cycle, no Done, Hi/Lo keep old values.
//   Second Start pulsed while busy -> ignored; exactly one Done. Stall high cycles 1..34.
//   Reset low asserted mid-RUN -> Stall, Done, Hi, Lo all 0 with no clock edge. Next Start works.

Source files
------------

// File: rtl/execute_muldiv_unit.sv
// execute_muldiv_unit
//   Iterative MULT/MULTU/DIV/DIVU unit on the Execute side of ID/EX.
//   A request takes WIDTH+2 cycles; o_stall holds Decode/ID-EX while busy
//   and the architectural HI/LO pair is updated when the result commits.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for i_start; operands and signs captured on start
//   RUN    | one radix-2 step per cycle, WIDTH cycles
//   FIX    | sign correction of the unsigned-magnitude result
//   DONE   | o_done pulse; o_hi/o_lo already hold the new result
//
// Ports
//   i_clk     rising-edge clock
//   i_rst_n   asynchronous active-low reset
//   i_start   request valid, sampled in IDLE only
//   i_op      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   i_op_a    multiplicand / dividend
//   i_op_b    multiplier / divisor
//   i_flush   abort an in-flight operation (RUN/FIX) or drop a start
//   o_stall   high whenever not IDLE
//   o_done    one-cycle completion pulse
//   o_hi      product high half or remainder
//   o_lo      product low half or quotient
module execute_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  input  logic             i_flush,
  output logic             o_stall,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [1:0]         r_op;
  logic               r_neg_a;
  logic               r_neg_res;
  logic               r_div0;
  logic [WIDTH-1:0]   r_a;      // multiplicand, or dividend shifting into quotient
  logic [WIDTH-1:0]   r_b;      // multiplier (shifts right), or divisor
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_rem;
  logic [CW-1:0]      r_cnt;

  logic               w_signed_op;
  logic               w_sign_a;
  logic               w_sign_b;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_diff;
  logic               w_div_ok;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [2*WIDTH-1:0] w_res;

  assign w_signed_op = ~i_op[0];
  assign w_sign_a    = w_signed_op & i_op_a[WIDTH-1];
  assign w_sign_b    = w_signed_op & i_op_b[WIDTH-1];
  assign w_abs_a     = w_sign_a ? -i_op_a : i_op_a;
  assign w_abs_b     = w_sign_b ? -i_op_b : i_op_b;

  // Shift-add: add into the upper half, then shift the whole accumulator right.
  assign w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_b[0] ? r_a : '0)};

  // Restoring divide. The partial remainder stays below the divisor, so the
  // W+1-bit difference cannot overflow and its MSB is the borrow.
  assign w_div_shift = {r_rem, r_a[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_b};
  assign w_div_ok    = ~w_div_diff[WIDTH];

  // Divide by zero naturally yields remainder = |A| (sign-fixed back to A);
  // only the quotient needs forcing to all-ones.
  assign w_prod = r_neg_res ? -r_acc : r_acc;
  assign w_quo  = r_div0 ? '1 : (r_neg_res ? -r_a : r_a);
  assign w_rem  = r_neg_a ? -r_rem : r_rem;
  assign w_res  = r_op[1] ? {w_rem, w_quo} : w_prod;

  assign o_stall = (r_state != S_IDLE);
  assign o_done  = (r_state == S_DONE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_start && !i_flush) w_next = S_RUN;
      S_RUN: begin
        if (i_flush)                         w_next = S_IDLE;
        else if (r_cnt == CW'(WIDTH - 1))    w_next = S_FIX;
      end
      S_FIX:  w_next = i_flush ? S_IDLE : S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op      <= '0;
      r_neg_a   <= 1'b0;
      r_neg_res <= 1'b0;
      r_div0    <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      o_hi      <= '0;
      o_lo      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start && !i_flush) begin
            r_op      <= i_op;
            r_neg_a   <= w_sign_a;
            r_neg_res <= w_sign_a ^ w_sign_b;
            r_div0    <= (i_op_b == '0);
            r_a       <= w_abs_a;
            r_b       <= w_abs_b;
            r_acc     <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_op[1]) begin
            r_rem <= w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
            r_a   <= {r_a[WIDTH-2:0], w_div_ok};
          end else begin
            r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
            r_b   <= r_b >> 1;
          end
        end
        // Result lands on the edge into DONE so it is visible with o_done.
        S_FIX: begin
          if (!i_flush) begin
            o_hi <= w_res[2*WIDTH-1:WIDTH];
            o_lo <= w_res[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_muldiv_unit.sv
module tb_execute_muldiv_unit;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  opa;
  logic [W-1:0]  opb;
  logic          flush;
  logic          stall;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  execute_muldiv_unit #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op),
    .i_op_a(opa), .i_op_b(opb), .i_flush(flush),
    .o_stall(stall), .o_done(done), .o_hi(hi), .o_lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           start_cyc;
  } exp_t;

  exp_t         sb_q[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           pushed = 0;
  int           seen = 0;
  logic [W-1:0] cur_hi = '0;
  logic [W-1:0] cur_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: straight arithmetic on 64-bit values.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint       sa;
    longint       sb;
    longint       sq;
    longint       sr;
    logic [63:0]  ua;
    logic [63:0]  ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      2'd0: begin sq = sa * sb; return sq; end
      2'd1: return ua * ub;
      2'd2: begin
        if (b == '0) return {a, 32'hFFFF_FFFF};
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      default: begin
        if (b == '0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  // Monitor: every Done must match the oldest expected entry, on time.
  always @(negedge clk) begin
    if (rst_n && done) begin
      seen++;
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("hi", 64'(hi), 64'(e.hi));
        check("lo", 64'(lo), 64'(e.lo));
        check("latency", 64'(cyc - e.start_cyc + 1), 64'(LAT));
        check("stall_in_done", 64'(stall), 64'd1);
        cur_hi = e.hi;
        cur_lo = e.lo;
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    exp_t e;
    logic [63:0] r;
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b;
    if (push) begin
      r = model(o, a, b);
      e.hi = r[63:32];
      e.lo = r[31:0];
      e.start_cyc = cyc + 1;
      sb_q.push_back(e);
      pushed++;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int exp_n, input string name);
    int n = 0;
    while (stall && n < 200) begin
      n++;
      @(negedge clk);
    end
    check(name, 64'(n), 64'(exp_n));
  endtask

  task automatic run(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    issue(o, a, b, 1'b1);
    wait_idle(LAT, "stall_cycles");
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; opa = '0; opb = '0;
    #2;
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(2'd0, -32'sd3, 32'd7);
    run(2'd2, -32'sd7, 32'd2);
    run(2'd3, 32'd100, 32'd0);
    run(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run(2'd2, -32'sd7, 32'd0);
    run(2'd0, 32'h8000_0000, 32'h8000_0000);

    // Second start while busy must be ignored.
    issue(2'd1, 32'd12345, 32'd678, 1'b1);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'd3; opa = 32'd999; opb = 32'd7;
    @(negedge clk);
    start = 1'b0;
    wait_idle(LAT - 5, "busy_stall_cycles");
    repeat (40) @(negedge clk);
    check("busy_one_done", 64'(seen), 64'(pushed));

    // Flush at RUN cycle 10.
    issue(2'd0, 32'd11, 32'd13, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_run_stall", 64'(stall), 64'd0);
    check("flush_run_hilo", {hi, lo}, {cur_hi, cur_lo});

    // Flush in FIX.
    issue(2'd2, -32'sd100, 32'd3, 1'b0);
    repeat (LAT - 2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_fix_stall", 64'(stall), 64'd0);
    repeat (40) @(negedge clk);
    check("flush_fix_hilo", {hi, lo}, {cur_hi, cur_lo});
    check("flush_no_done", 64'(seen), 64'(pushed));

    // Flush with start in IDLE drops the request.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'd1; opa = 32'd5; opb = 32'd6;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start_stall", 64'(stall), 64'd0);
    repeat (40) @(negedge clk);
    check("flush_start_no_done", 64'(seen), 64'(pushed));

    // Flush during DONE: result still commits.
    issue(2'd3, 32'd1000, 32'd7, 1'b1);
    n = 0;
    while (!done && n < 60) begin
      n++;
      @(negedge clk);
    end
    check("done_seen_in_time", 64'(done), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_done_stall", 64'(stall), 64'd0);
    check("flush_done_hilo", {hi, lo}, {32'd6, 32'd142});

    // Asynchronous reset mid-RUN.
    issue(2'd1, 32'd77, 32'd55, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_stall", 64'(stall), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_hilo", {hi, lo}, 64'd0);
    cur_hi = '0;
    cur_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run(2'd1, 32'd77, 32'd55);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]   o;
      logic [W-1:0] a;
      logic [W-1:0] b;
      o = 2'($urandom_range(0, 3));
      a = pick();
      b = pick();
      run(o, a, b);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 64'(sb_q.size()), 64'd0);
    check("done_count", 64'(seen), 64'(pushed));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
